// File: rtl/grain_pkg.sv
// Shared definitions for the Grain byte cipher wrapper: widths, defaults and FSM states.
package grain_pkg;

    localparam int SEED_W                = 104;
    localparam int WARMUP_CYCLES_DEFAULT = 160;
    localparam int KS_W                  = 8;
    localparam int KS_CNT_W              = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WARMUP  = 3'd2,
        WAIT_IN = 3'd3,
        GEN     = 3'd4,
        OUT     = 3'd5
    } state_t;

endpackage

// File: rtl/grain_ks_packer.sv
// Collects eight generator bits LSB-first into a keystream byte.
// The eighth bit is taken live from bit_in, so ks_byte is complete in the cycle done is high.
module grain_ks_packer
    import grain_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            shift_en,
    input  logic            bit_in,
    output logic [KS_W-1:0] ks_byte,
    output logic            done
);

    logic [KS_W-2:0]     sr_q, sr_d;
    logic [KS_CNT_W-1:0] cnt_q, cnt_d;

    // Shift a new bit in at the top and count bits; the counter wraps every byte.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (shift_en) begin
            sr_d  = {bit_in, sr_q[KS_W-2:1]};
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign ks_byte = {bit_in, sr_q};
    assign done    = shift_en && (cnt_q == {KS_CNT_W{1'b1}});

    // State registers, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/grain_byte_cipher.sv
// Control and data stage around the Grain keystream generator: seed load, warm-up,
// then per byte eight keystream bits are packed and XORed with the input byte.
module grain_byte_cipher #(
    parameter int WARMUP_CYCLES = grain_pkg::WARMUP_CYCLES_DEFAULT,
    parameter int SEED_W        = grain_pkg::SEED_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEED_W-1:0] seed_in,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              key_par_load,
    output logic              key_shift_en,
    output logic [SEED_W-1:0] key_seed,
    input  logic              key_bit
);

    import grain_pkg::*;

    // Counter sized to hold WARMUP_CYCLES-1 without wrapping; 1 bit when warm-up is disabled.
    localparam int              WU_W    = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
    localparam logic [WU_W-1:0] WU_LAST = WU_W'(WARMUP_CYCLES - 1);

    state_t            state_q, state_d;
    logic [SEED_W-1:0] key_seed_q, key_seed_d;
    logic [WU_W-1:0]   wu_cnt_q, wu_cnt_d;
    logic [7:0]        data_q, data_d;
    logic              last_q, last_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              key_par_load_q, key_par_load_d;
    logic              key_shift_en_q, key_shift_en_d;

    logic [KS_W-1:0]   ks_byte;
    logic              ks_done;

    grain_ks_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .shift_en (state_q == GEN),
        .bit_in   (key_bit),
        .ks_byte  (ks_byte),
        .done     (ks_done)
    );

    // Next-state logic; the strobes are decoded from the next state so they come out of flops.
    always_comb begin
        state_d    = state_q;
        key_seed_d = key_seed_q;
        wu_cnt_d   = wu_cnt_q;
        data_d     = data_q;
        last_d     = last_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_seed_d = seed_in;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                wu_cnt_d = '0;
                state_d  = (WARMUP_CYCLES == 0) ? WAIT_IN : WARMUP;
            end
            WARMUP: begin
                if (wu_cnt_q == WU_LAST) begin
                    state_d = WAIT_IN;
                end else begin
                    wu_cnt_d = wu_cnt_q + 1'b1;
                end
            end
            WAIT_IN: begin
                // in_ready is high throughout WAIT_IN, so in_valid alone is the handshake.
                if (in_valid) begin
                    data_d  = in_data;
                    last_d  = in_last;
                    state_d = GEN;
                end
            end
            GEN: begin
                if (ks_done) begin
                    out_data_d = data_q ^ ks_byte;
                    out_last_d = last_q;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = out_last_q ? IDLE : WAIT_IN;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d     = (state_d == WAIT_IN);
        out_valid_d    = (state_d == OUT);
        busy_d         = (state_d != IDLE);
        key_par_load_d = (state_d == LOAD);
        key_shift_en_d = (state_d == WARMUP) || (state_d == GEN);
    end

    // All state and outputs; reset clears everything immediately, mid-session included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            key_seed_q     <= '0;
            wu_cnt_q       <= '0;
            data_q         <= '0;
            last_q         <= 1'b0;
            out_data_q     <= '0;
            out_last_q     <= 1'b0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            key_par_load_q <= 1'b0;
            key_shift_en_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_seed_q     <= key_seed_d;
            wu_cnt_q       <= wu_cnt_d;
            data_q         <= data_d;
            last_q         <= last_d;
            out_data_q     <= out_data_d;
            out_last_q     <= out_last_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            busy_q         <= busy_d;
            key_par_load_q <= key_par_load_d;
            key_shift_en_q <= key_shift_en_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign busy         = busy_q;
    assign key_par_load = key_par_load_q;
    assign key_shift_en = key_shift_en_q;
    assign key_seed     = key_seed_q;

endmodule

// File: tb/tb_grain_byte_cipher.sv
// Testbench for grain_byte_cipher: a bit-stream generator model, a table-driven session,
// reset and warm-up corner cases, randomized sessions, and a zero-warm-up instance.
module tb_grain_byte_cipher;

    localparam int SEED_W = 104;
    localparam int WARM   = 160;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [SEED_W-1:0] seed_in = '0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready, out_valid, out_last, busy, key_par_load, key_shift_en;
    logic [7:0]        out_data;
    logic              out_ready = 1'b0;
    logic [SEED_W-1:0] key_seed;
    logic              key_bit;

    logic              z_start = 1'b0;
    logic [SEED_W-1:0] z_seed_in = '0;
    logic              z_in_valid = 1'b0;
    logic [7:0]        z_in_data = '0;
    logic              z_in_last = 1'b0;
    logic              z_in_ready, z_out_valid, z_out_last, z_busy, z_key_par_load, z_key_shift_en;
    logic [7:0]        z_out_data;
    logic              z_out_ready = 1'b0;
    logic [SEED_W-1:0] z_key_seed;
    logic              z_key_bit = 1'b1;

    always #5 clk = ~clk;

    grain_byte_cipher #(.WARMUP_CYCLES(WARM), .SEED_W(SEED_W)) dut (
        .clk(clk), .rst(rst), .start(start), .seed_in(seed_in),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .key_par_load(key_par_load), .key_shift_en(key_shift_en),
        .key_seed(key_seed), .key_bit(key_bit)
    );

    grain_byte_cipher #(.WARMUP_CYCLES(0), .SEED_W(SEED_W)) dut0 (
        .clk(clk), .rst(rst), .start(z_start), .seed_in(z_seed_in),
        .in_valid(z_in_valid), .in_data(z_in_data), .in_last(z_in_last), .in_ready(z_in_ready),
        .out_valid(z_out_valid), .out_data(z_out_data), .out_last(z_out_last), .out_ready(z_out_ready),
        .busy(z_busy), .key_par_load(z_key_par_load), .key_shift_en(z_key_shift_en),
        .key_seed(z_key_seed), .key_bit(z_key_bit)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Generator model: a bit stream that restarts on load and advances once per shift.
    logic [2047:0] stream;
    int            gen_idx;
    always @(posedge clk or negedge rst) begin
        if (!rst)              gen_idx <= 0;
        else if (key_par_load) gen_idx <= 0;
        else if (key_shift_en) gen_idx <= gen_idx + 1;
    end
    assign key_bit = stream[gen_idx[10:0]];

    // Load and shift must never be requested together.
    always @(negedge clk) begin
        if (rst) begin
            check("mutex", {key_par_load & key_shift_en, z_key_par_load & z_key_shift_en}, 2'b00);
        end
    end

    task automatic fill_stream();
        for (int i = 0; i < 64; i++) stream[i*32 +: 32] = $urandom;
    endtask

    // Keystream byte k of a session: bits WARM+8k .. WARM+8k+7, first bit in the LSB.
    function automatic logic [7:0] ks_of(input int k);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = stream[WARM + 8*k + j];
        return b;
    endfunction

    task automatic start_session(input logic [SEED_W-1:0] seed);
        int n_shift;
        int n_par;
        int i;
        @(negedge clk); start = 1'b1; seed_in = seed;
        @(negedge clk); start = 1'b0; seed_in = ~seed;
        check("seed_latch", key_seed, seed);
        check("par_load", key_par_load, 1'b1);
        check("shift_in_load", key_shift_en, 1'b0);
        check("busy_load", busy, 1'b1);
        n_shift = 0;
        n_par   = 0;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) break;
            n_shift += int'(key_shift_en);
            n_par   += int'(key_par_load);
        end
        check("warmup_len", n_shift, WARM);
        check("in_ready_cycle", i, WARM);
        check("par_load_once", n_par, 0);
    endtask

    task automatic xfer(input logic [7:0] d, input logic last, input logic [7:0] exp,
                        input int stall, input bit poke_start);
        int lat;
        for (int w = 0; w < 20 && !in_ready; w++) @(negedge clk);
        check("in_ready_wait", in_ready, 1'b1);
        in_valid = 1'b1; in_data = d; in_last = last;
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            check("gen_shift", key_shift_en, 1'b1);
            check("gen_in_ready", in_ready, 1'b0);
            start = poke_start && (lat == 2);
            if (start) seed_in = {4{32'($urandom)}};
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", lat, 9);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", out_data, exp);
            check("stall_last", out_last, last);
            check("stall_shift", key_shift_en, 1'b0);
            check("stall_in_ready", in_ready, 1'b0);
        end
        check("out_data", out_data, exp);
        check("out_last", out_last, last);
        $display("byte in=%02h last=%0d -> out=%02h (want %02h) stall=%0d", d, last, out_data, exp, stall);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", out_valid, 1'b0);
        check("post_busy", busy, !last);
        check("post_in_ready", in_ready, !last);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] ks;
        logic [7:0] exp;
        int         stall;
        bit         poke;
    } vec_t;

    vec_t tbl[3];

    initial begin
        logic [SEED_W-1:0] seed_a5;
        logic [SEED_W-1:0] cur_seed;
        int                nb;
        logic [7:0]        d;

        tbl[0] = '{8'hFF, 1'b0, 8'h8D, 8'h72, 5, 1'b0};
        tbl[1] = '{8'h00, 1'b0, 8'h5A, 8'h5A, 0, 1'b1};
        tbl[2] = '{8'hC3, 1'b1, 8'h3C, 8'hFF, 2, 1'b0};

        fill_stream();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_par", key_par_load, 1'b0);
        check("rst_shift", key_shift_en, 1'b0);
        check("rst_seed", key_seed, '0);
        check("rst_out_data", {out_data, out_last}, 9'h0);
        check("rst_z_busy", z_busy, 1'b0);
        rst = 1'b1;

        // A5 seed with the table session: keystream 8D on byte 0, start poked on byte 1.
        for (int k = 0; k < 3; k++) stream[WARM + 8*k +: 8] = tbl[k].ks;
        seed_a5 = {13{8'hA5}};
        start_session(seed_a5);
        for (int k = 0; k < 3; k++) begin
            xfer(tbl[k].data, tbl[k].last, tbl[k].exp, tbl[k].stall, tbl[k].poke);
        end
        check("seed_kept", key_seed, seed_a5);

        // Reset asserted mid-GEN clears everything without a clock edge.
        fill_stream();
        cur_seed = {4{32'($urandom)}};
        start_session(cur_seed);
        in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_shift", key_shift_en, 1'b0);
        check("arst_in_ready", in_ready, 1'b0);
        check("arst_out", {out_valid, out_data, out_last}, 10'h0);
        check("arst_seed", key_seed, '0);
        @(negedge clk); @(negedge clk);
        check("arst_hold_busy", busy, 1'b0);
        rst = 1'b1;
        cur_seed = {4{32'($urandom)}};
        start_session(cur_seed);
        xfer(8'h55, 1'b1, 8'h55 ^ ks_of(0), 1, 1'b0);

        // Randomized sessions against the bit-stream model.
        for (int s = 0; s < 4; s++) begin
            fill_stream();
            cur_seed = {4{32'($urandom)}};
            nb = $urandom_range(1, 4);
            start_session(cur_seed);
            for (int k = 0; k < nb; k++) begin
                d = 8'($urandom);
                xfer(d, k == nb - 1, d ^ ks_of(k), $urandom_range(0, 3), 1'b0);
            end
        end

        // Zero warm-up instance: LOAD goes straight to WAIT_IN.
        @(negedge clk); z_start = 1'b1; z_seed_in = {4{32'($urandom)}};
        @(negedge clk); z_start = 1'b0;
        check("z_par_load", z_key_par_load, 1'b1);
        check("z_shift_load", z_key_shift_en, 1'b0);
        @(negedge clk);
        check("z_in_ready", z_in_ready, 1'b1);
        check("z_shift_wait", z_key_shift_en, 1'b0);
        z_in_valid = 1'b1; z_in_data = 8'h5A; z_in_last = 1'b1;
        @(negedge clk); z_in_valid = 1'b0;
        for (int w = 0; w < 20 && !z_out_valid; w++) @(negedge clk);
        check("z_out_valid", z_out_valid, 1'b1);
        check("z_out_data", z_out_data, 8'hA5);
        check("z_out_last", z_out_last, 1'b1);
        $display("z byte in=5a last=1 -> out=%02h (want a5)", z_out_data);
        z_out_ready = 1'b1;
        @(negedge clk); z_out_ready = 1'b0;
        check("z_busy_end", z_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
